// File: rtl/fp_inst_encode.sv
// Streaming RV32F/D instruction encoder: turns FP operation descriptors into 32-bit
// instruction words and queues them in a small FIFO. Illegal descriptors are counted and dropped.
module fp_inst_encode #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready,
    input  logic [3:0]               op_i,
    input  logic [2:0]               minor_i,
    input  logic [1:0]               fmt_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [4:0]               rs3_i,
    input  logic [2:0]               rm_i,
    input  logic [11:0]              imm_i,
    input  logic                     flush_i,
    output logic                     inst_valid,
    input  logic                     inst_ready_i,
    output logic [31:0]              inst,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         n_encoded,
    output logic [CNT_W-1:0]         n_errors
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {K_OPFP, K_FMA, K_LOAD, K_STORE} kind_e;

    kind_e       kind;
    logic [4:0]  funct5;
    logic [4:0]  rs2_f;
    logic [2:0]  f3;
    logic [2:0]  ls_f3;
    logic [2:0]  minor_max;
    logic        uses_rm;
    logic        s_only;
    logic [31:0] enc_word;
    logic [1:0]  enc_code;

    always_comb begin
        kind      = K_OPFP;
        funct5    = 5'b00000;
        rs2_f     = rs2_i;
        f3        = rm_i;
        minor_max = 3'd0;
        uses_rm   = 1'b0;
        s_only    = 1'b0;
        case (op_i)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                funct5  = {3'b000, op_i[1:0]};
                uses_rm = 1'b1;
            end
            4'd4: begin
                funct5    = 5'b00100;
                f3        = minor_i;
                minor_max = 3'd2;
            end
            4'd5: begin
                funct5    = 5'b00101;
                f3        = minor_i;
                minor_max = 3'd1;
            end
            4'd6: begin
                funct5  = 5'b01011;
                rs2_f   = 5'd0;
                uses_rm = 1'b1;
            end
            4'd7: begin
                funct5    = 5'b10100;
                f3        = minor_i;
                minor_max = 3'd2;
            end
            4'd8: begin
                // minor 0 moves integer into FP (W.X), minor 1 moves FP into integer (X.W)
                funct5    = minor_i[0] ? 5'b11100 : 5'b11110;
                rs2_f     = 5'd0;
                f3        = 3'b000;
                minor_max = 3'd1;
                s_only    = 1'b1;
            end
            4'd9, 4'd10: begin
                funct5    = (op_i == 4'd9) ? 5'b11010 : 5'b11000;
                rs2_f     = {4'b0000, minor_i[0]};
                minor_max = 3'd1;
                uses_rm   = 1'b1;
            end
            4'd11: begin
                // fmt_i names the destination; rs2 names the opposite (source) format
                funct5  = 5'b01000;
                rs2_f   = {4'b0000, ~fmt_i[0]};
                uses_rm = 1'b1;
            end
            4'd12: begin
                funct5 = 5'b11100;
                rs2_f  = 5'd0;
                f3     = 3'b001;
            end
            4'd13: begin
                kind      = K_FMA;
                minor_max = 3'd3;
                uses_rm   = 1'b1;
            end
            4'd14: kind = K_LOAD;
            default: kind = K_STORE;
        endcase

        ls_f3 = {2'b01, fmt_i[0]};
        case (kind)
            K_FMA:   enc_word = {rs3_i, fmt_i, rs2_i, rs1_i, rm_i, rd_i, 2'b10, minor_i[1:0], 3'b011};
            K_LOAD:  enc_word = {imm_i, rs1_i, ls_f3, rd_i, 7'h07};
            K_STORE: enc_word = {imm_i[11:5], rs2_i, rs1_i, ls_f3, imm_i[4:0], 7'h27};
            default: enc_word = {funct5, fmt_i, rs2_f, rs1_i, f3, rd_i, 7'h53};
        endcase

        if (fmt_i[1] || (s_only && fmt_i[0]))
            enc_code = 2'd1;
        else if (minor_i > minor_max)
            enc_code = 2'd2;
        else if (uses_rm && (rm_i == 3'b101 || rm_i == 3'b110))
            enc_code = 2'd3;
        else
            enc_code = 2'd0;
    end

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [CNT_W-1:0] n_enc_q;
    logic [CNT_W-1:0] n_err_q;
    logic             accept;
    logic             push;
    logic             pop;

    assign req_ready  = (level_q < LW'(DEPTH)) && !flush_i;
    assign accept     = req_valid_i && req_ready;
    assign push       = accept && (enc_code == 2'd0);
    assign inst_valid = (level_q != '0);
    assign pop        = inst_valid && inst_ready_i;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            n_enc_q    <= '0;
            n_err_q    <= '0;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                level_q <= level_d;
            end
            err_q <= accept && (enc_code != 2'd0);
            if (accept && (enc_code != 2'd0)) begin
                err_code_q <= enc_code;
                n_err_q    <= n_err_q + 1'b1;
            end
            if (push) n_enc_q <= n_enc_q + 1'b1;
        end
    end

    // Storage needs no reset: inst_valid gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

    assign inst      = inst_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign level     = level_q;
    assign n_encoded = n_enc_q;
    assign n_errors  = n_err_q;
endmodule

// File: tb/tb_fp_inst_encode.sv
// Directed bench for fp_inst_encode; a queue scoreboard holds expected words from accept to pop.
module tb_fp_inst_encode;
    logic        clk_i = 1'b0;
    logic        rst_i, req_valid_i, req_ready, flush_i;
    logic [3:0]  op_i;
    logic [2:0]  minor_i, rm_i;
    logic [1:0]  fmt_i, err_code;
    logic [4:0]  rd_i, rs1_i, rs2_i, rs3_i;
    logic [11:0] imm_i;
    logic        inst_valid, inst_ready_i, err;
    logic [31:0] inst;
    logic [2:0]  level;
    logic [15:0] n_encoded, n_errors;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic        exp_legal;
    logic [31:0] exp_word;
    logic        accepted;
    int          exp_enc = 0;

    fp_inst_encode #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready(req_ready),
        .op_i(op_i), .minor_i(minor_i), .fmt_i(fmt_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .rs3_i(rs3_i), .rm_i(rm_i), .imm_i(imm_i), .flush_i(flush_i),
        .inst_valid(inst_valid), .inst_ready_i(inst_ready_i), .inst(inst), .err(err),
        .err_code(err_code), .level(level), .n_encoded(n_encoded), .n_errors(n_errors)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] opfp(input logic [4:0] f5, input logic [1:0] fmt,
                                         input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f5, fmt, rs2, rs1, f3, rd, 7'h53};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes just before the edge, then return at the next negedge.
    task automatic tick();
        #1;
        if (inst_valid && inst_ready_i && !flush_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty observed=%h expected=none", inst);
            end else begin
                chk("sb_inst", inst, sb_q.pop_front());
            end
        end
        if (req_valid_i && req_ready) begin
            accepted = 1'b1;
            if (exp_legal) begin
                sb_q.push_back(exp_word);
                exp_enc++;
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic set_req(input logic [3:0] op, input logic [2:0] mn, input logic [1:0] fmt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rs3, input logic [2:0] rm, input logic [11:0] imm,
                           input logic legal, input logic [31:0] word);
        op_i = op; minor_i = mn; fmt_i = fmt; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        rs3_i = rs3; rm_i = rm; imm_i = imm; exp_legal = legal; exp_word = word;
        req_valid_i = 1'b1;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] mn, input logic [1:0] fmt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rs3, input logic [2:0] rm, input logic [11:0] imm,
                        input logic legal, input logic [31:0] word);
        set_req(op, mn, fmt, rd, rs1, rs2, rs3, rm, imm, legal, word);
        accepted = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) tick();
        if (!accepted) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=%0d expected=1", accepted);
        end
        req_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; inst_ready_i = 1'b1;
        op_i = '0; minor_i = '0; fmt_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        rs3_i = '0; rm_i = '0; imm_i = '0; exp_legal = 1'b0; exp_word = '0; accepted = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_n_encoded", n_encoded, 0);
        chk("rst_n_errors", n_errors, 0);
        chk("rst_req_ready", req_ready, 1);

        // Reference encodings with a ready sink; latency is one cycle after accept
        send(4'd0, 3'd0, 2'd0, 5'd5, 5'd1, 5'd2, 5'd0, 3'd0, 12'd0, 1'b1, 32'h002082D3);
        chk("fadd_latency", inst_valid, 1);
        chk("fadd_n_encoded", n_encoded, 1);
        tick();
        send(4'd13, 3'd0, 2'd0, 5'd6, 5'd1, 5'd2, 5'd3, 3'd0, 12'd0, 1'b1, 32'h18208343);
        send(4'd14, 3'd0, 2'd0, 5'd2, 5'd1, 5'd0, 5'd0, 3'd0, 12'd4, 1'b1, 32'h0040A107);
        send(4'd15, 3'd0, 2'd1, 5'd0, 5'd1, 5'd5, 5'd0, 3'd0, 12'h010, 1'b1, 32'h0050B827);
        tick();
        chk("ref_level", level, 0);

        // Illegal descriptors in priority order fmt, minor, rm
        send(4'd2, 3'd0, 2'd2, 5'd1, 5'd1, 5'd1, 5'd0, 3'd0, 12'd0, 1'b0, 32'd0);
        chk("err_fmt_pulse", err, 1);
        chk("err_fmt_code", err_code, 1);
        send(4'd7, 3'd3, 2'd0, 5'd1, 5'd1, 5'd1, 5'd0, 3'd0, 12'd0, 1'b0, 32'd0);
        chk("err_minor_pulse", err, 1);
        chk("err_minor_code", err_code, 2);
        send(4'd0, 3'd0, 2'd0, 5'd1, 5'd1, 5'd1, 5'd0, 3'd5, 12'd0, 1'b0, 32'd0);
        chk("err_rm_pulse", err, 1);
        chk("err_rm_code", err_code, 3);
        tick();
        chk("err_pulse_end", err, 0);
        chk("err_code_hold", err_code, 3);
        chk("err_n_errors", n_errors, 3);
        chk("err_level", level, 0);
        chk("err_inst_valid", inst_valid, 0);

        // Backpressure: four FSUB.D fill the FIFO, fifth stalls
        inst_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            send(4'd1, 3'd0, 2'd1, 5'(i + 8), 5'(i + 1), 5'(i + 2), 5'd0, 3'd1, 12'd0, 1'b1,
                 opfp(5'b00001, 2'd1, 5'(i + 2), 5'(i + 1), 3'd1, 5'(i + 8)));
        set_req(4'd2, 3'd0, 2'd0, 5'd3, 5'd3, 5'd3, 5'd0, 3'd0, 12'd0, 1'b1,
                opfp(5'b00010, 2'd0, 5'd3, 5'd3, 3'd0, 5'd3));
        tick();
        tick();
        chk("full_req_ready", req_ready, 0);
        chk("full_level", level, 4);
        chk("full_head_stable", inst, sb_q[0]);
        req_valid_i = 1'b0;
        inst_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", inst_valid, 1);
            tick();
        end
        chk("drain_empty", inst_valid, 0);
        chk("drain_level", level, 0);

        // Hold at level 2 with simultaneous push and pop, then flush
        inst_ready_i = 1'b0;
        send(4'd4, 3'd1, 2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 3'd0, 12'd0, 1'b1,
             opfp(5'b00100, 2'd0, 5'd3, 5'd2, 3'd1, 5'd1));
        send(4'd5, 3'd1, 2'd1, 5'd4, 5'd5, 5'd6, 5'd0, 3'd0, 12'd0, 1'b1,
             opfp(5'b00101, 2'd1, 5'd6, 5'd5, 3'd1, 5'd4));
        chk("pp_level_pre", level, 2);
        inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(4'd7, 3'(i), 2'd0, 5'(i + 10), 5'(i + 11), 5'(i + 12), 5'd0, 3'd0, 12'd0, 1'b1,
                 opfp(5'b10100, 2'd0, 5'(i + 12), 5'(i + 11), 3'(i), 5'(i + 10)));
            chk("pp_level", level, 2);
        end
        inst_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sb_q.delete();
        chk("flush_level", level, 0);
        chk("flush_inst_valid", inst_valid, 0);
        chk("flush_n_encoded", n_encoded, 32'(exp_enc));

        // FCVT fp->fp source format in rs2, FMV.X.W restricted to single
        inst_ready_i = 1'b1;
        send(4'd11, 3'd0, 2'd0, 5'd7, 5'd8, 5'd0, 5'd0, 3'd7, 12'd0, 1'b1,
             opfp(5'b01000, 2'd0, 5'd1, 5'd8, 3'd7, 5'd7));
        send(4'd11, 3'd0, 2'd1, 5'd9, 5'd10, 5'd0, 5'd0, 3'd2, 12'd0, 1'b1,
             opfp(5'b01000, 2'd1, 5'd0, 5'd10, 3'd2, 5'd9));
        tick();
        tick();
        send(4'd8, 3'd1, 2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 3'd0, 12'd0, 1'b0, 32'd0);
        chk("fmv_d_err", err, 1);
        chk("fmv_d_code", err_code, 1);
        chk("final_n_errors", n_errors, 4);
        chk("final_n_encoded", n_encoded, 32'(exp_enc));
        chk("sb_left", 32'(sb_q.size()), 0);

        // Reset mid-stream drops queued words and counters on the same edge
        inst_ready_i = 1'b0;
        send(4'd12, 3'd0, 2'd0, 5'd1, 5'd2, 5'd0, 5'd0, 3'd0, 12'd0, 1'b1,
             opfp(5'b11100, 2'd0, 5'd0, 5'd2, 3'd1, 5'd1));
        chk("pre_rst_level", level, 1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        sb_q.delete();
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", inst_valid, 0);
        chk("mid_rst_n_encoded", n_encoded, 0);
        chk("mid_rst_n_errors", n_errors, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
